// File: rtl/memory_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : memory_decoder_if
//  Description : Bus bundle between the arbiter memory port, the decoder and
//                the peripheral slaves.
//                  memory_*  : single-master request/response port
//                  slave_*   : fan-out port towards SLAVES peripherals
//                modport slave  - the decoder's view (answers memory_*,
//                                 drives slave_* requests)
//                modport master - the surrounding system's view (arbiter
//                                 plus peripherals)
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_decoder_if #(
    parameter int SLAVES = 4,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    logic                 memory_valid;
    logic                 memory_instr;
    logic [AW-1:0]        memory_addr;
    logic [DW-1:0]        memory_wdata;
    logic [DW/8-1:0]      memory_wstrb;
    logic [DW-1:0]        memory_rdata;
    logic                 memory_ready;
    logic                 memory_error;

    logic [SLAVES-1:0]    slave_valid;
    logic                 slave_instr;
    logic [AW-1:0]        slave_addr;
    logic [DW-1:0]        slave_wdata;
    logic [DW/8-1:0]      slave_wstrb;
    logic [SLAVES*DW-1:0] slave_rdata;
    logic [SLAVES-1:0]    slave_ready;

    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready, memory_error,
        output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
        input  slave_rdata, slave_ready
    );

    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready, memory_error,
        input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
        output slave_rdata, slave_ready
    );
endinterface
`default_nettype wire

// File: rtl/memory_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : memory_decoder
//  Description : Single-master, N-slave memory bus decoder with tracked
//                transactions. Routes each request to the lowest-indexed
//                address window that contains it (address rebased to the
//                window), returns only the selected slave's response, answers
//                unmapped addresses with an error and times out silent slaves.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous, active-high
//                bus    - memory_decoder_if.slave (memory_* and slave_* buses)
//                status - sticky flags {protocol violation, timeout, decode err}
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_decoder #(
    parameter int                   SLAVES    = 4,
    parameter int                   AW        = 32,
    parameter int                   DW        = 32,
    parameter logic [SLAVES*AW-1:0] BASE_ADDR = {32'h00800000, 32'h00100000,
                                                 32'h00200000, 32'h00000000},
    parameter logic [SLAVES*AW-1:0] TOP_ADDR  = {32'h00801000, 32'h00100004,
                                                 32'h00210000, 32'h00100000},
    parameter int                   TIMEOUT   = 1023
) (
    input  logic             clock,
    input  logic             reset,
    memory_decoder_if.slave  bus,
    output logic [2:0]       status
);

    localparam int          C_IW      = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [C_IW-1:0]   r_sel_q,   w_sel_d;
    logic [15:0]       r_cnt_q,   w_cnt_d;
    logic [2:0]        r_status_q, w_status_d;

    logic              w_hit;
    logic [C_IW-1:0]   w_hit_idx;
    logic [AW-1:0]     w_hit_base;
    logic              w_sel_ready;
    logic [DW-1:0]     w_sel_rdata;
    logic [SLAVES-1:0] w_slave_valid;
    logic              w_mem_ready;
    logic              w_mem_error;
    logic [DW-1:0]     w_mem_rdata;

    // Address decode. Scanning from the top index down lets a lower index
    // overwrite the result, so the lowest matching window wins on overlap.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_base = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if ((bus.memory_addr >= BASE_ADDR[i*AW +: AW]) &&
                (bus.memory_addr <  TOP_ADDR[i*AW +: AW])) begin
                w_hit      = 1'b1;
                w_hit_idx  = C_IW'(i);
                w_hit_base = BASE_ADDR[i*AW +: AW];
            end
        end
    end

    assign w_sel_ready = bus.slave_ready[r_sel_q];
    assign w_sel_rdata = bus.slave_rdata[r_sel_q*DW +: DW];

    // Next-state and response logic.
    always_comb begin
        w_state_d     = r_state_q;
        w_sel_d       = r_sel_q;
        w_cnt_d       = r_cnt_q;
        w_status_d    = r_status_q;
        w_slave_valid = '0;
        w_mem_ready   = 1'b0;
        w_mem_error   = 1'b0;
        w_mem_rdata   = '0;
        case (r_state_q)
            S_IDLE: begin
                if (bus.memory_valid) begin
                    if (w_hit) begin
                        w_slave_valid[w_hit_idx] = 1'b1;
                        w_sel_d   = w_hit_idx;
                        w_cnt_d   = '0;
                        w_state_d = S_BUSY;
                    end else begin
                        w_status_d[0] = 1'b1;
                        w_state_d     = S_ERR;
                    end
                end
            end
            S_BUSY: begin
                // A slave answer in the timeout cycle takes priority.
                if (w_sel_ready) begin
                    w_mem_ready = 1'b1;
                    w_mem_rdata = w_sel_rdata;
                    w_state_d   = S_IDLE;
                end else if (r_cnt_q == C_TIMEOUT) begin
                    w_mem_ready   = 1'b1;
                    w_mem_error   = 1'b1;
                    w_status_d[1] = 1'b1;
                    w_state_d     = S_IDLE;
                end else if (r_cnt_q != C_CNT_MAX) begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
                if (bus.memory_valid) begin
                    w_status_d[2] = 1'b1;
                end
            end
            S_ERR: begin
                w_mem_ready = 1'b1;
                w_mem_error = 1'b1;
                w_state_d   = S_IDLE;
                if (bus.memory_valid) begin
                    w_status_d[2] = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_sel_q    <= '0;
            r_cnt_q    <= '0;
            r_status_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_sel_q    <= w_sel_d;
            r_cnt_q    <= w_cnt_d;
            r_status_q <= w_status_d;
        end
    end

    // Every output, including the broadcast copies, is forced low while reset
    // is asserted so nothing leaks out before the state register is cleared.
    assign bus.slave_valid  = reset ? '0   : w_slave_valid;
    assign bus.slave_instr  = reset ? 1'b0 : bus.memory_instr;
    assign bus.slave_addr   = reset ? '0   :
                              (w_hit ? (bus.memory_addr - w_hit_base) : bus.memory_addr);
    assign bus.slave_wdata  = reset ? '0   : bus.memory_wdata;
    assign bus.slave_wstrb  = reset ? '0   : bus.memory_wstrb;
    assign bus.memory_ready = reset ? 1'b0 : w_mem_ready;
    assign bus.memory_error = reset ? 1'b0 : w_mem_error;
    assign bus.memory_rdata = reset ? '0   : w_mem_rdata;
    assign status           = reset ? 3'b0 : r_status_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_memory_decoder
//  Description : Self-checking bench for memory_decoder (TIMEOUT = 8). The
//                stimulus side predicts each response from the window table
//                and the slave's answer delay and queues it; a monitor pops
//                and compares whenever memory_ready is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_decoder;

    localparam int SLAVES = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TMO    = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] status;

    memory_decoder_if #(.SLAVES(SLAVES), .AW(AW), .DW(DW)) bus ();

    memory_decoder #(
        .SLAVES    (SLAVES),
        .AW        (AW),
        .DW        (DW),
        .BASE_ADDR ({32'h00800000, 32'h00100000, 32'h00200000, 32'h00000000}),
        .TOP_ADDR  ({32'h00801000, 32'h00100004, 32'h00210000, 32'h00100000}),
        .TIMEOUT   (TMO)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .status (status)
    );

    always #5 clock = ~clock;

    // Window table of the reference model (index = slave number).
    logic [31:0] m_base [SLAVES] = '{32'h00000000, 32'h00200000, 32'h00100000, 32'h00800000};
    logic [31:0] m_top  [SLAVES] = '{32'h00100000, 32'h00210000, 32'h00100004, 32'h00801000};

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          at;
    } resp_t;

    resp_t      q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [2:0] exp_status = 3'b000;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < SLAVES; i++) begin
            if (a >= m_base[i] && a < m_top[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: every memory_ready must match the oldest predicted response.
    always @(negedge clock) begin
        if (!reset && bus.memory_ready) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                resp_t r;
                r = q.pop_front();
                check("resp_error", 64'(bus.memory_error), 64'(r.err));
                check("resp_rdata", 64'(bus.memory_rdata), 64'(r.data));
                check("resp_cycle", 64'(cyc), 64'(r.at));
            end
        end
    end

    task automatic idle_inputs();
        bus.memory_valid = 1'b0;
        bus.slave_ready  = '0;
        bus.slave_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // noise: -1 none, -2 random other slave, >=0 that slave index
    task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input logic instr,
                       input logic [31:0] rd, input int delay,
                       input int noise, input bit violate);
        int          s, vcyc, resp_k, last_k, o;
        bit          late;
        logic [3:0]  ev;
        s = decode(addr);
        @(posedge clock); #1;
        bus.memory_valid = 1'b1;
        bus.memory_addr  = addr;
        bus.memory_wstrb = wstrb;
        bus.memory_wdata = wdata;
        bus.memory_instr = instr;
        vcyc = cyc;
        #3;
        ev = 4'b0000;
        if (s >= 0) ev[s] = 1'b1;
        check("req_slave_valid", 64'(bus.slave_valid), 64'(ev));
        check("req_slave_addr", 64'(bus.slave_addr), (s >= 0) ? 64'(addr - m_base[s]) : 64'(addr));
        check("req_broadcast", {bus.slave_wdata, 27'd0, bus.slave_instr, bus.slave_wstrb},
              {wdata, 27'd0, instr, wstrb});
        late = 1'b0;
        if (s < 0) begin
            exp_status[0] = 1'b1;
            q.push_back('{1'b1, 32'h0, vcyc + 1});
            resp_k = 1;
        end else if (delay <= TMO + 1) begin
            q.push_back('{1'b0, rd, vcyc + delay});
            resp_k = delay;
        end else begin
            exp_status[1] = 1'b1;
            q.push_back('{1'b1, 32'h0, vcyc + TMO + 1});
            resp_k = TMO + 1;
            late   = 1'b1;
        end
        last_k = late ? TMO + 2 : resp_k;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clock); #1;
            idle_inputs();
            if (violate && k == 1) begin
                bus.memory_valid = 1'b1;
                bus.memory_addr  = $urandom();
                exp_status[2]    = 1'b1;
            end
            if (noise != -1 && k <= resp_k) begin
                if (noise >= 0)  o = noise;
                else if (s < 0)  o = int'($urandom_range(0, 3));
                else             o = (s + 1 + int'($urandom_range(0, 2))) % SLAVES;
                if (o != s) bus.slave_ready[o] = 1'b1;
            end
            if (s >= 0 && (k == delay || (late && k == TMO + 2))) begin
                bus.slave_ready[s]           = 1'b1;
                bus.slave_rdata[s*32 +: 32]  = rd;
            end
            if (violate && k == 1) begin
                #3;
                check("viol_slave_valid", 64'(bus.slave_valid), 64'd0);
            end
        end
        @(posedge clock); #1;
        idle_inputs();
        check("status", 64'(status), 64'(exp_status));
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        int          nz;

        idle_inputs();
        bus.memory_instr = 1'b1;
        bus.memory_addr  = 32'h00000040;
        bus.memory_wdata = 32'hFFFF_FFFF;
        bus.memory_wstrb = 4'hF;
        bus.memory_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_slave_valid", 64'(bus.slave_valid), 64'd0);
        check("rst_slave_addr", 64'(bus.slave_addr), 64'd0);
        check("rst_mem_outputs", {bus.memory_rdata, 30'd0, bus.memory_ready, bus.memory_error}, 64'd0);
        check("rst_status", 64'(status), 64'd0);
        reset = 1'b0;
        idle_inputs();

        // Directed cases.
        txn(32'h00000040, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 2, -1, 1'b0);
        txn(32'h00200008, 4'hF, 32'h12345678, 1'b0, 32'hCAFEF00D, 3, 3, 1'b0);
        txn(32'h00100000, 4'h0, 32'h0, 1'b1, 32'h0BADC0DE, TMO + 1, -1, 1'b0);
        txn(32'h00400000, 4'h0, 32'h0, 1'b0, 32'h11111111, 2, -1, 1'b0);
        txn(32'h00100002, 4'h0, 32'h0, 1'b0, 32'h22222222, 30, -1, 1'b0);
        txn(32'h00000040, 4'h3, 32'hA5A5A5A5, 1'b0, 32'h33333333, 3, -1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 4));
            if (kind < SLAVES) a = m_base[kind] + ($urandom() % (m_top[kind] - m_base[kind]));
            else               a = $urandom();
            nz = ($urandom_range(0, 1) == 1) ? -2 : -1;
            txn(a, 4'($urandom()), $urandom(), 1'($urandom()), $urandom(),
                int'($urandom_range(1, 12)), nz, ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        // Reset in the middle of a transaction.
        @(posedge clock); #1;
        bus.memory_valid = 1'b1;
        bus.memory_addr  = 32'h00000040;
        @(posedge clock); #1;
        reset = 1'b1;
        #3;
        check("midrst_slave_valid", 64'(bus.slave_valid), 64'd0);
        check("midrst_slave_addr", 64'(bus.slave_addr), 64'd0);
        check("midrst_mem_outputs", {bus.memory_rdata, 30'd0, bus.memory_ready, bus.memory_error}, 64'd0);
        @(posedge clock); #1;
        reset            = 1'b0;
        exp_status       = 3'b000;
        bus.memory_valid = 1'b0;
        bus.slave_ready  = 4'b0001;
        #3;
        check("late_ready_ignored", 64'(bus.memory_ready), 64'd0);
        @(posedge clock); #1;
        idle_inputs();
        check("status_after_reset", 64'(status), 64'(exp_status));

        repeat (3) @(posedge clock);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_decoder.md
# memory_decoder

Parametrised single-master, N-slave memory bus decoder for the SoC memory port. It sits between the arbiter's `memory_*` port and the peripheral slaves (bram, clint, print, rom, …). It replaces the fixed four-way combinational address split with a tracked transaction state machine, which provides:
- response routing from the addressed slave only;
- rebased slave addresses;
- error responses for unmapped addresses;
- a timeout watchdog for slaves that never answer.

## Interface
Parameters:
- `SLAVES`, 4, number of slave windows (1–16).
- `AW`, 32, address width.
- `DW`, 32, data width; `wstrb` width is `DW/8`.
- `BASE_ADDR`, `{32'h00800000,32'h00100000,32'h00200000,32'h00000000}`, packed `SLAVES*AW` window bases; slave 0 occupies the LSBs.
- `TOP_ADDR`, `{32'h00801000,32'h00100004,32'h00210000,32'h00100000}`, packed exclusive window tops.
- `TIMEOUT`, 1023, number of BUSY cycles without `slave_ready` before an error response; range 1 to 2^16−1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memory_valid` in 1: one-cycle request strobe.
- `memory_instr` in 1: instruction-fetch qualifier.
- `memory_addr` in AW: request address.
- `memory_wdata` in DW: write data.
- `memory_wstrb` in DW/8: byte strobes; all zero means read.
- `memory_rdata` out DW: response data.
- `memory_ready` out 1: one-cycle response strobe.
- `memory_error` out 1: qualifies `memory_ready`; decode error or timeout.
- `slave_valid` out SLAVES: one-hot request strobe.
- `slave_instr` out 1: broadcast copy of `memory_instr`.
- `slave_addr` out AW: address rebased to the selected window.
- `slave_wdata` out DW: broadcast write data.
- `slave_wstrb` out DW/8: broadcast strobes.
- `slave_rdata` in SLAVES*DW: packed per-slave read data.
- `slave_ready` in SLAVES: per-slave response strobe.
- `status` out 3: sticky flags. Bit 0 is decode error, bit 1 is timeout, bit 2 is protocol violation.

## Operation
Decode:
- Hit[i] is true when `BASE[i] <= memory_addr < TOP[i]`, using unsigned AW-bit compares.
- When windows overlap, the lowest index wins.
- `slave_valid[sel] = memory_valid` in the same cycle, only in IDLE.
- `slave_addr = memory_addr − BASE[sel]`. When no window hits, `slave_addr = memory_addr` and all `slave_valid` bits are 0.

State machine IDLE / BUSY / ERR:
- IDLE, valid with a hit: latch `sel` and clear the counter; go to BUSY.
- IDLE, valid with no hit: set `status[0]`; go to ERR.
- BUSY, `slave_ready[sel]` = 1: drive `memory_ready` = 1, `memory_rdata = slave_rdata[sel]` and `memory_error` = 0; go to IDLE.
- BUSY, counter reaches TIMEOUT while `slave_ready[sel]` is 0: drive `memory_ready` = 1, `memory_error` = 1 and `memory_rdata` = 0. Set `status[1]` and go to IDLE.
- ERR: drive `memory_ready` = 1, `memory_error` = 1 and `memory_rdata` = 0; go to IDLE.

Rules in every state:
- `slave_ready` from any index other than `sel`, or received outside BUSY, is ignored. It never reaches `memory_ready`.
- A `memory_valid` while in BUSY or ERR is a protocol violation. It is dropped, no `slave_valid` is issued, and `status[2]` is set.
- If `slave_ready[sel]` arrives in the same cycle the counter reaches TIMEOUT, the slave response wins. There is no error and `status[1]` is unchanged.
- The counter is 16 bits, increments once per BUSY cycle, and saturates.
- The `status` bits are cleared only by reset.

## Timing
Reset behaviour:
- While `reset` = 1 at a rising edge: state becomes IDLE; `sel`, the counter and `status` become 0.
- All outputs are 0 during reset, including `slave_valid`, `memory_ready`, `memory_error` and `memory_rdata`.
- Reset in mid-transaction abandons the transaction. No response is issued, and a late `slave_ready` is ignored because the state is IDLE.

Latency:
- Request forwarding has zero cycles of latency: combinational from the `memory_*` inputs in IDLE.
- Slave response: `memory_ready` is combinational from `slave_ready[sel]` in BUSY, adding zero cycles.
- A slave `ready` in the request cycle itself is ignored. Slaves must answer at least 1 cycle after `valid`.
- Decode error: `memory_ready` arrives 1 cycle after `memory_valid`.
- Timeout: the error response occurs in the cycle in which the counter equals TIMEOUT.
  - The counter is 0 in the first BUSY cycle.
  - The response therefore arrives TIMEOUT+1 cycles after `memory_valid`.

Throughput:
- One outstanding transaction.
- A new `memory_valid` is legal in the cycle after `memory_ready`.

## Test plan
- Read to slave 0 at 0x00000040; slave 0 readies after 2 cycles with 0xDEADBEEF.
  - `slave_valid` = 0001 and `slave_addr` = 0x40.
  - `memory_ready` fires 2 cycles later with 0xDEADBEEF and `memory_error` = 0.
- Write 0x12345678, `wstrb` = 1111, to 0x00200008.
  - `slave_valid` = 0010 and `slave_addr` = 0x8.
  - Slave 1 `ready` is returned with `memory_error` = 0.
  - Slave 3 pulsing `ready` during BUSY produces no `memory_ready`.
- Read from 0x00400000 (unmapped).
  - `slave_valid` stays 0.
  - Next cycle: `memory_ready` = 1, `memory_error` = 1, `memory_rdata` = 0; `status` = 001.
- TIMEOUT=8 override, slave 2 never readies.
  - Error response arrives exactly 9 cycles after `valid`; `status[1]` = 1.
  - A later slave 2 `ready` is ignored.
- TIMEOUT=8, slave 2 readies exactly at counter=8.
  - Normal response, `memory_error` = 0; `status[1]` = 0.
- Second `memory_valid` 1 cycle into BUSY.
  - It is dropped and `status[2]` = 1; the first transaction completes normally.
- `reset` asserted during BUSY.
  - All outputs are 0; the late slave `ready` produces no `memory_ready`.
